// File: rtl/xsim_mem_arbiter_if.sv
// Bus bundles for the xsim memory arbiter: the client side carries N request/response
// lanes; the memory side is the single port into the simulation memory model.
interface xsim_cli_if #(parameter int N = 4);
  logic [N-1:0]    cli_req_valid;
  logic [N-1:0]    cli_req_write;
  logic [N*32-1:0] cli_req_addr;
  logic [N*32-1:0] cli_req_handle;
  logic [N*32-1:0] cli_req_data;
  logic [N-1:0]    cli_req_ready;
  logic [N-1:0]    cli_rsp_valid;
  logic [31:0]     cli_rsp_data;
  logic [N-1:0]    cli_rsp_ready;

  modport master (
    output cli_req_valid, cli_req_write, cli_req_addr, cli_req_handle, cli_req_data,
    output cli_rsp_ready,
    input  cli_req_ready, cli_rsp_valid, cli_rsp_data
  );

  modport slave (
    input  cli_req_valid, cli_req_write, cli_req_addr, cli_req_handle, cli_req_data,
    input  cli_rsp_ready,
    output cli_req_ready, cli_rsp_valid, cli_rsp_data
  );
endinterface

interface xsim_mem_if;
  logic        mem_rdy_readrequest;
  logic        mem_en_readrequest;
  logic [31:0] mem_readrequest_addr;
  logic [31:0] mem_readrequest_handle;
  logic        mem_rdy_readresponse;
  logic [31:0] mem_readresponse_data;
  logic        mem_en_readresponse;
  logic        mem_en_write32;
  logic [31:0] mem_write32_addr;
  logic [31:0] mem_write32_handle;
  logic [31:0] mem_write32_data;

  modport master (
    input  mem_rdy_readrequest, mem_rdy_readresponse, mem_readresponse_data,
    output mem_en_readrequest, mem_readrequest_addr, mem_readrequest_handle,
    output mem_en_readresponse,
    output mem_en_write32, mem_write32_addr, mem_write32_handle, mem_write32_data
  );

  modport slave (
    output mem_rdy_readrequest, mem_rdy_readresponse, mem_readresponse_data,
    input  mem_en_readrequest, mem_readrequest_addr, mem_readrequest_handle,
    input  mem_en_readresponse,
    input  mem_en_write32, mem_write32_addr, mem_write32_handle, mem_write32_data
  );
endinterface

// File: rtl/xsim_mem_arbiter.sv
// Round-robin arbiter sharing one xsim memory port among NUM_CLIENTS requesters;
// read issue order is kept in a tag FIFO so returning beats route to their owner.
module xsim_mem_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  xsim_cli_if.slave   cli,
  xsim_mem_if.master  mem,
  output logic        orphan_rsp
);
  localparam int PW = $clog2(NUM_CLIENTS);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_tag [TAG_DEPTH];
  logic [TW-1:0] r_wr_ptr;
  logic [TW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_orphan_rsp;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_found;
  logic                   w_is_wr;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_rsp_v;
  logic                   w_en_wr;
  logic [PW-1:0]          w_gnt;
  logic [PW-1:0]          w_head;
  logic [PW-1:0]          w_rr_next;
  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_one;
  logic [31:0]            w_addr;
  logic [31:0]            w_handle;
  logic [31:0]            w_data;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_elig  = cli.cli_req_valid &
                   (cli.cli_req_write | {NUM_CLIENTS{mem.mem_rdy_readrequest & ~w_full}});

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_gnt   = PW'(idx);
      end
    end
  end

  assign w_one     = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};
  assign w_is_wr   = cli.cli_req_write[w_gnt];
  assign w_rr_next = (w_gnt == PW'(NUM_CLIENTS - 1)) ? '0 : w_gnt + 1'b1;
  assign w_addr    = cli.cli_req_addr[{w_gnt, 5'd0} +: 32];
  assign w_handle  = cli.cli_req_handle[{w_gnt, 5'd0} +: 32];
  assign w_data    = cli.cli_req_data[{w_gnt, 5'd0} +: 32];
  assign w_en_wr   = RST_N & w_found & w_is_wr;
  assign w_push    = RST_N & w_found & ~w_is_wr;

  assign w_head  = r_tag[r_rd_ptr];
  assign w_rsp_v = RST_N & ~w_empty & mem.mem_rdy_readresponse;
  assign w_pop   = w_rsp_v & cli.cli_rsp_ready[w_head];

  assign cli.cli_req_ready = (RST_N && w_found) ? (w_one << w_gnt) : '0;
  assign cli.cli_rsp_valid = w_rsp_v ? (w_one << w_head) : '0;
  assign cli.cli_rsp_data  = w_rsp_v ? mem.mem_readresponse_data : '0;

  assign mem.mem_en_readrequest     = w_push;
  assign mem.mem_readrequest_addr   = w_push ? w_addr : '0;
  assign mem.mem_readrequest_handle = w_push ? w_handle : '0;
  assign mem.mem_en_write32         = w_en_wr;
  assign mem.mem_write32_addr       = w_en_wr ? w_addr : '0;
  assign mem.mem_write32_handle     = w_en_wr ? w_handle : '0;
  assign mem.mem_write32_data       = w_en_wr ? w_data : '0;
  assign mem.mem_en_readresponse    = w_pop;

  assign orphan_rsp = r_orphan_rsp;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_orphan_rsp <= 1'b0;
    end else begin
      if (w_found) r_rr_ptr <= w_rr_next;
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (mem.mem_rdy_readresponse && w_empty) r_orphan_rsp <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge CLK) begin
    if (w_push) r_tag[r_wr_ptr] <= w_gnt;
  end
endmodule

// File: tb/tb_xsim_mem_arbiter.sv
// Scoreboard bench for xsim_mem_arbiter: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor pops and compares them against the DUT.
module tb_xsim_mem_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic orphan;
  always #5 clk = ~clk;

  xsim_cli_if #(.N(N)) cli();
  xsim_mem_if          mem();

  xsim_mem_arbiter #(.NUM_CLIENTS(N), .TAG_DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n), .cli(cli), .mem(mem), .orphan_rsp(orphan)
  );

  typedef struct {
    logic [N-1:0] req_ready;
    logic         en_rd;
    logic [31:0]  rd_addr, rd_handle;
    logic         en_wr;
    logic [31:0]  wr_addr, wr_handle, wr_data;
    logic [N-1:0] rsp_valid;
    logic [31:0]  rsp_data;
    logic         en_rsp;
    logic         orphan;
  } exp_t;

  exp_t exp_q[$];
  int   m_tags[$];
  int   m_rr = 0;
  bit   m_orphan = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("req_ready", 192'(cli.cli_req_ready), 192'(e.req_ready));
      chk("mem_read", 192'({mem.mem_en_readrequest, mem.mem_readrequest_addr, mem.mem_readrequest_handle}),
          192'({e.en_rd, e.rd_addr, e.rd_handle}));
      chk("mem_write", 192'({mem.mem_en_write32, mem.mem_write32_addr, mem.mem_write32_handle, mem.mem_write32_data}),
          192'({e.en_wr, e.wr_addr, e.wr_handle, e.wr_data}));
      chk("rsp", 192'({cli.cli_rsp_valid, cli.cli_rsp_data, mem.mem_en_readresponse}),
          192'({e.rsp_valid, e.rsp_data, e.en_rsp}));
      chk("orphan", 192'(orphan), 192'(e.orphan));
    end
  end

  // Predict this cycle from the current inputs, advance the model, then wait one clock.
  task automatic step();
    exp_t e;
    int   g;
    e = '{default: '0};
    g = -1;
    if (!rst_n) begin
      m_rr = 0;
      m_tags.delete();
      m_orphan = 1'b0;
    end
    e.orphan = m_orphan;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && cli.cli_req_valid[idx] &&
            (cli.cli_req_write[idx] || (mem.mem_rdy_readrequest && m_tags.size() < D)))
          g = idx;
      end
      if (mem.mem_rdy_readresponse) begin
        if (m_tags.size() == 0) m_orphan = 1'b1;
        else begin
          int h;
          h = m_tags[0];
          e.rsp_valid[h] = 1'b1;
          e.rsp_data = mem.mem_readresponse_data;
          if (cli.cli_rsp_ready[h]) begin
            e.en_rsp = 1'b1;
            void'(m_tags.pop_front());
          end
        end
      end
      if (g >= 0) begin
        e.req_ready[g] = 1'b1;
        if (cli.cli_req_write[g]) begin
          e.en_wr     = 1'b1;
          e.wr_addr   = cli.cli_req_addr[32*g +: 32];
          e.wr_handle = cli.cli_req_handle[32*g +: 32];
          e.wr_data   = cli.cli_req_data[32*g +: 32];
        end else begin
          e.en_rd     = 1'b1;
          e.rd_addr   = cli.cli_req_addr[32*g +: 32];
          e.rd_handle = cli.cli_req_handle[32*g +: 32];
          m_tags.push_back(g);
        end
        m_rr = (g + 1) % N;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cli.cli_req_valid = '0;
    cli.cli_req_write = '0;
    cli.cli_req_addr = '0;
    cli.cli_req_handle = '0;
    cli.cli_req_data = '0;
    cli.cli_rsp_ready = '0;
    mem.mem_rdy_readrequest = 1'b0;
    mem.mem_rdy_readresponse = 1'b0;
    mem.mem_readresponse_data = '0;
  endtask

  task automatic set_cli(int i, bit v, bit w, logic [31:0] a, logic [31:0] h, logic [31:0] d);
    cli.cli_req_valid[i] = v;
    cli.cli_req_write[i] = w;
    cli.cli_req_addr[32*i +: 32] = a;
    cli.cli_req_handle[32*i +: 32] = h;
    cli.cli_req_data[32*i +: 32] = d;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle();
    mem.mem_rdy_readresponse = 1'b1;
    cli.cli_rsp_ready = '1;
    while (m_tags.size() != 0 && guard < 20) begin
      mem.mem_readresponse_data = $urandom;
      step();
      guard++;
    end
    chk("drain_done", 192'(m_tags.size()), 192'(0));
    idle();
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    // reset with every client requesting
    for (int i = 0; i < N; i++) set_cli(i, 1'b1, 1'b1, 32'h100 + i, 32'h5, 32'h1000_0000 + i);
    mem.mem_rdy_readrequest = 1'b1;
    mem.mem_rdy_readresponse = 1'b1;
    mem.mem_readresponse_data = 32'h1234_5678;
    cli.cli_rsp_ready = '1;
    step();
    step();
    rst_n = 1'b1;
    mem.mem_rdy_readresponse = 1'b0;
    repeat (5) step();

    // read routing
    idle();
    set_cli(2, 1'b1, 1'b0, 32'h40, 32'h7, 32'h0);
    mem.mem_rdy_readrequest = 1'b1;
    step();
    idle();
    mem.mem_rdy_readresponse = 1'b1;
    mem.mem_readresponse_data = 32'hdead_beef;
    step();
    cli.cli_rsp_ready = 4'b0100;
    step();
    idle();
    chk("count_after_rsp", 192'(dut.r_count), 192'(0));

    // mixed read/write with read port busy
    set_cli(1, 1'b1, 1'b0, 32'h80, 32'h9, 32'h0);
    set_cli(3, 1'b1, 1'b1, 32'hc0, 32'h9, 32'h33);
    step();
    set_cli(3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    mem.mem_rdy_readrequest = 1'b1;
    step();
    drain();

    // full tag FIFO
    for (int i = 0; i < N; i++) set_cli(i, 1'b1, 1'b0, 32'h200 + 4*i, 32'h3, 32'h0);
    mem.mem_rdy_readrequest = 1'b1;
    repeat (D) step();
    chk("count_full", 192'(dut.r_count), 192'(D));
    idle();
    mem.mem_rdy_readrequest = 1'b1;
    set_cli(0, 1'b1, 1'b0, 32'h300, 32'h3, 32'h0);
    set_cli(1, 1'b1, 1'b1, 32'h304, 32'h3, 32'haaaa_5555);
    step();
    set_cli(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    mem.mem_rdy_readresponse = 1'b1;
    mem.mem_readresponse_data = 32'hcafe_0001;
    cli.cli_rsp_ready = '1;
    step();
    mem.mem_rdy_readresponse = 1'b0;
    step();
    chk("count_refill", 192'(dut.r_count), 192'(D));
    drain();

    // orphan response
    chk("orphan_clear", 192'(orphan), 192'(0));
    mem.mem_rdy_readresponse = 1'b1;
    mem.mem_readresponse_data = 32'h0bad_0bad;
    step();
    idle();
    step();
    chk("orphan_sticky", 192'(orphan), 192'(1));

    // randomized traffic with occasional mid-operation reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        set_cli(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      mem.mem_rdy_readrequest = ($urandom_range(0, 3) != 0);
      mem.mem_rdy_readresponse = ($urandom_range(0, 1) == 1);
      mem.mem_readresponse_data = $urandom;
      cli.cli_rsp_ready = N'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    step();
    chk("orphan_after_reset", 192'(orphan), 192'(0));
    chk("scoreboard_empty", 192'(exp_q.size()), 192'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xsim_mem_arbiter.md
# xsim_mem_arbiter

Round-robin arbiter that shares the single simulation memory port of the xsim memory read/write model among `NUM_CLIENTS` requesters. Each cycle it selects at most one eligible read or 32-bit write request and forwards it to the memory port. It records the client index of every issued read in an in-order tag FIFO, and routes each returning read beat back to the client that issued it. It sits between the DMA/client engines of `mkXsimTop` and the DPI-backed memory model.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `TAG_DEPTH`, 4: maximum outstanding reads. Power of two, ≥2.

Ports:
- `CLK`  in  1  sole clock; all state updates on posedge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `cli_req_valid`  in  N  per-client request valid.
- `cli_req_write`  in  N  per-client 1=write32, 0=read.
- `cli_req_addr`  in  N*32  per-client address; client i occupies bits [32i+31:32i].
- `cli_req_handle`  in  N*32  per-client memory handle.
- `cli_req_data`  in  N*32  per-client write data; ignored for reads.
- `cli_req_ready`  out  N  one-hot or zero; the request is accepted when valid and ready are both high.
- `cli_rsp_valid`  out  N  one-hot or zero; read data is available for that client.
- `cli_rsp_data`  out  32  read data, shared by all clients.
- `cli_rsp_ready`  in  N  per-client response consume.
- `mem_rdy_readrequest`  in  1  memory can accept a read.
- `mem_en_readrequest`  out  1  issue read.
- `mem_readrequest_addr`, `mem_readrequest_handle`  out  32 each.
- `mem_rdy_readresponse`  in  1  memory holds valid read data.
- `mem_readresponse_data`  in  32.
- `mem_en_readresponse`  out  1  consume read data.
- `mem_en_write32`  out  1  issue write.
- `mem_write32_addr`, `mem_write32_handle`, `mem_write32_data`  out  32 each.

## Operation
- **Eligibility.**
  - Client i is eligible if `cli_req_valid[i]` is high and either `cli_req_write[i]` is 1, or `mem_rdy_readrequest` is 1 and the tag FIFO is not full.
  - Writes need no memory ready.
- **Grant.**
  - The grant goes to the first eligible client searching upward from `rr_ptr`, wrapping modulo N.
  - On a grant to client g, `rr_ptr` <= (g+1) mod N. With no grant, `rr_ptr` holds.
  - At most one grant per cycle.
- **Issue.**
  - `cli_req_ready[g]` = 1.
  - For a write: `mem_en_write32` = 1 with client g's addr, handle and data.
  - For a read: `mem_en_readrequest` = 1 with client g's addr and handle, and g is pushed into the tag FIFO.
  - The `mem_*` address, handle and data buses are don't-care when the matching enable is 0. Drive 0 in that case.
- **Response routing.**
  - When the FIFO is non-empty and `mem_rdy_readresponse` = 1, `cli_rsp_valid[head]` = 1 and `cli_rsp_data` = `mem_readresponse_data`.
  - When `cli_rsp_ready[head]` is also 1, `mem_en_readresponse` = 1 and the FIFO pops.
  - `cli_rsp_ready` of non-head clients is ignored.
- **Simultaneous events.**
  - A push and a pop may occur in the same cycle; the occupancy count is unchanged.
  - Full is evaluated on the registered count, before the same-cycle pop. A full FIFO blocks reads even when a pop occurs that cycle.
- **State.** `rr_ptr` (clog2 N bits), FIFO storage, read/write pointers (clog2 `TAG_DEPTH` bits, wrapping), and `count` (0..`TAG_DEPTH`).
- **Error flag.** A memory response with an empty FIFO is an error. The block ignores it (no `cli_rsp_valid`, no `mem_en_readresponse`) and sets sticky internal flag `orphan_rsp`, which is cleared only by reset.

## Timing
- **Reset.**
  - `RST_N` low asynchronously clears `rr_ptr` = 0, `count` = 0, FIFO pointers = 0 and `orphan_rsp` = 0.
  - While `RST_N` is low, every output is forced to 0 regardless of inputs.
- **Request path.** Combinational from `cli_req_*` and `mem_rdy_readrequest` to `cli_req_ready` and `mem_*` request outputs. The client sees zero added latency.
- **Response path.** Combinational from `mem_rdy_readresponse` and data to `cli_rsp_*`. Zero added latency.
- **Throughput.** One request per cycle. Reads are limited by `mem_rdy_readrequest` (memory model: one outstanding read, one-cycle response).
- **Reset mid-operation.** Reset discards FIFO contents. Outstanding memory responses arriving after reset are orphans and set `orphan_rsp`.
- **Ordering.** Responses return in issue order across all clients.

## Test plan
- **Reset outputs.** Hold `RST_N` = 0 with all `cli_req_valid` = 1 -> all outputs 0. Deassert -> client 0 granted first.
- **Round-robin rotation.** N=4, all clients issue continuous writes -> grant order 0,1,2,3,0. Each `mem_en_write32` carries the granted client's data, e.g. 32'h1000_000i.
- **Read routing.** Client 2 reads addr 0x40 and the memory returns 32'hdeadbeef -> `cli_rsp_valid` = 4'b0100 with that data. `cli_rsp_ready[2]` -> `mem_en_readresponse` pulses once and `count` returns to 0.
- **Mixed read/write.** Client 1 reads while client 3 writes and `mem_rdy_readrequest` = 0 -> client 3 is granted, client 1 waits. The read issues the cycle `mem_rdy_readrequest` rises.
- **Full FIFO.** `TAG_DEPTH` = 4 reads outstanding with responses withheld -> no further read granted, but a write from another client still issues. One pop -> reads resume the next cycle.
- **Orphan response.** Assert `mem_rdy_readresponse` with an empty FIFO -> no `cli_rsp_valid`, `mem_en_readresponse` = 0, `orphan_rsp` = 1 until reset.
